boid_pixel_writer: RTL and testbench

BOID_PIXEL_WRITER -- requirements
Module: boid_pixel_writer

---
 rtl/boid_pixel_writer.sv | 120 ++++++++++++
 tb/tb_boid_pixel_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/boid_pixel_writer.sv
// Erases a boid's previous pixel and draws its new one in the framebuffer.
// One position is accepted at a time; writes stall while write_allow is low.
module boid_pixel_writer #(
    parameter int VIDEO_WIDTH         = 640,
    parameter int VIDEO_HEIGHT        = 480,
    parameter int PIXEL_ADDRESS_WIDTH = 20,
    parameter int COLOR_WIDTH         = 9,
    parameter int BG_COLOR            = 0,
    parameter int BOID_COLOR          = 1
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [9:0]                     in_x,
    input  logic [8:0]                     in_y,
    input  logic                           write_allow,
    output logic                           wr_en,
    output logic [PIXEL_ADDRESS_WIDTH-1:0] wr_addr,
    output logic [COLOR_WIDTH-1:0]         wr_data,
    output logic                           oob_err,
    output logic [15:0]                    draw_count,
    output logic [1:0]                     state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        ERASE = 2'd2,
        DRAW  = 2'd3
    } state_t;

    localparam logic [10:0] X_LIMIT = 11'(VIDEO_WIDTH);
    localparam logic [9:0]  Y_LIMIT = 10'(VIDEO_HEIGHT);

    state_t                         state, state_nxt;
    logic [9:0]                     x_q;
    logic [8:0]                     y_q;
    logic [PIXEL_ADDRESS_WIDTH-1:0] addr_calc;
    logic [PIXEL_ADDRESS_WIDTH-1:0] new_addr;
    logic [PIXEL_ADDRESS_WIDTH-1:0] prev_addr;
    logic                           prev_valid;
    logic                           oob;
    logic                           accept;

    // Handshake: a position transfers on a posedge where in_valid && in_ready;
    // in_valid may be held without data loss, in_ready is high only in IDLE.
    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    // y*640 as y*512 + y*128, so no multiplier is needed.
    assign addr_calc = PIXEL_ADDRESS_WIDTH'(x_q)
                     + (PIXEL_ADDRESS_WIDTH'(y_q) << 9)
                     + (PIXEL_ADDRESS_WIDTH'(y_q) << 7);
    assign oob = ({1'b0, x_q} >= X_LIMIT) || ({1'b0, y_q} >= Y_LIMIT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            new_addr   <= '0;
            prev_addr  <= '0;
            prev_valid <= 1'b0;
            oob_err    <= 1'b0;
            draw_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                x_q <= in_x;
                y_q <= in_y;
            end
            if (state == ADDR) begin
                if (oob) oob_err  <= 1'b1;
                else     new_addr <= addr_calc;
            end
            if (state == DRAW && write_allow) begin
                prev_addr  <= new_addr;
                prev_valid <= 1'b1;
                if (draw_count != 16'hFFFF) draw_count <= draw_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ADDR;
            end
            ADDR: begin
                if (oob)                                  state_nxt = IDLE;
                else if (prev_valid && prev_addr != addr_calc) state_nxt = ERASE;
                else                                      state_nxt = DRAW;
            end
            ERASE: begin
                if (write_allow) begin
                    wr_en     = 1'b1;
                    wr_addr   = prev_addr;
                    wr_data   = COLOR_WIDTH'(BG_COLOR);
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (write_allow) begin
                    wr_en     = 1'b1;
                    wr_addr   = new_addr;
                    wr_data   = COLOR_WIDTH'(BOID_COLOR);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_boid_pixel_writer.sv
// Directed bench for boid_pixel_writer: a position-level model predicts every
// framebuffer write (cycle, address, colour) and the status outputs.
module tb_boid_pixel_writer;

    localparam int AW = 20;
    localparam int CW = 9;
    localparam int VW = 640;
    localparam int VH = 480;
    localparam int BG = 0;
    localparam int FG = 1;
    localparam int EW = 32 + AW + CW;

    logic          clock = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [9:0]    in_x;
    logic [8:0]    in_y;
    logic          write_allow;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          oob_err;
    logic [15:0]   draw_count;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_wr_addr = -1;

    // Each entry: {absolute cycle, address, colour} of an expected write.
    logic [EW-1:0] exp_q[$];

    // Position-level model of the block's persistent state.
    bit m_pv   = 1'b0;
    int m_prev = 0;
    int m_cnt  = 0;
    bit m_oob  = 1'b0;

    boid_pixel_writer dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .write_allow (write_allow),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .oob_err     (oob_err),
        .draw_count  (draw_count),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: every sampled cycle either matches the next expected write or is quiet
    always @(negedge clock) begin
        logic [EW-1:0] e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(wr_addr), 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_cycle", 64'(cyc), 64'(e[EW-1:AW+CW]));
                check("wr_addr", 64'(wr_addr), 64'(e[AW+CW-1:CW]));
                check("wr_data", 64'(wr_data), 64'(e[CW-1:0]));
            end
            last_wr_addr = int'(wr_addr);
        end else begin
            check("quiet_addr", 64'(wr_addr), 64'd0);
            check("quiet_data", 64'(wr_data), 64'd0);
        end
    end

    // driver: offer one position; write_allow is held low for `stall` cycles from cycle 2
    task automatic send(input int x, input int y, input int stall);
        int h, n, c, lat, new_addr;
        bit done;
        @(negedge clock);
        check("ready_before", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_x        = 10'(x);
        in_y        = 9'(y);
        write_allow = 1'b1;
        h = cyc;
        new_addr = x + y * VW;
        if (x >= VW || y >= VH) begin
            m_oob = 1'b1;
            lat = 2;
        end else begin
            c = h + 2 + stall;
            if (m_pv && m_prev != new_addr) begin
                exp_q.push_back({32'(c), AW'(m_prev), CW'(BG)});
                c++;
            end
            exp_q.push_back({32'(c), AW'(new_addr), CW'(FG)});
            lat = c + 1 - h;
            m_prev = new_addr;
            m_pv = 1'b1;
            if (m_cnt < 16'hFFFF) m_cnt++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_x = 10'($urandom_range(0, 1023));
        in_y = 9'($urandom_range(0, 511));
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            n = cyc - h;
            write_allow = (n >= 2 && n < 2 + stall) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (in_ready) done = 1'b1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        if (!done) begin
            check("ready_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end else begin
            check("ready_latency", 64'(cyc - h), 64'(lat));
            check("idle_state", 64'(state_dbg), 64'd0);
            check("draw_count", 64'(draw_count), 64'(m_cnt));
            check("oob_err", 64'(oob_err), 64'(m_oob));
            check("writes_drained", 64'(exp_q.size()), 64'd0);
        end
        write_allow = 1'b1;
    endtask

    initial begin
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_x        = '0;
        in_y        = '0;
        write_allow = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_oob", 64'(oob_err), 64'd0);
        check("rst_count", 64'(draw_count), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        resetn = 1'b1;

        // first draw, then a one-pixel move with erase
        send(10, 10, 0);
        check("pin_first_addr", 64'(last_wr_addr), 64'd6410);
        check("pin_first_count", 64'(draw_count), 64'd1);
        send(11, 10, 0);
        check("pin_move_addr", 64'(last_wr_addr), 64'd6411);
        check("pin_move_count", 64'(draw_count), 64'd2);

        // bottom-right corner, repeated without erase
        send(639, 479, 0);
        check("pin_corner_addr", 64'(last_wr_addr), 64'd307199);
        send(639, 479, 0);
        check("pin_corner_count", 64'(draw_count), 64'd4);

        // out-of-range positions are dropped
        send(640, 0, 0);
        send(0, 480, 0);
        check("pin_oob", 64'(oob_err), 64'd1);
        check("pin_oob_count", 64'(draw_count), 64'd4);

        // stalled erase: prev still 307199 after the drops
        send(11, 10, 5);
        check("pin_stall_addr", 64'(last_wr_addr), 64'd6411);

        // reset while DRAW is offering its write
        @(negedge clock);
        write_allow = 1'b0;
        in_valid    = 1'b1;
        in_x        = 10'd11;
        in_y        = 9'd10;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("hold_draw_state", 64'(state_dbg), 64'd3);
        check("hold_draw_wr_en", 64'(wr_en), 64'd0);
        write_allow = 1'b1;
        #1;
        check("draw_wr_en", 64'(wr_en), 64'd1);
        check("draw_wr_addr", 64'(wr_addr), 64'd6411);
        #1 resetn = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_addr", 64'(wr_addr), 64'd0);
        check("mid_rst_data", 64'(wr_data), 64'd0);
        check("mid_rst_state", 64'(state_dbg), 64'd0);
        check("mid_rst_count", 64'(draw_count), 64'd0);
        check("mid_rst_oob", 64'(oob_err), 64'd0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        m_pv = 1'b0;
        m_prev = 0;
        m_cnt = 0;
        m_oob = 1'b0;

        send(5, 0, 0);
        check("pin_after_rst_addr", 64'(last_wr_addr), 64'd5);
        check("pin_after_rst_count", 64'(draw_count), 64'd1);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
